seq_alu: RTL and testbench

SEQ_ALU -- requirements
Module: seq_alu

---
 rtl/seq_alu_pkg.sv | 42 ++++
 rtl/seq_alu_mul.sv | 75 +++++++
 rtl/seq_alu.sv | 175 +++++++++++++++++
 tb/tb_seq_alu.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_alu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : seq_alu_pkg
// Description : Shared definitions for the sequential ALU: operation
//               encodings, FSM state encoding and the legal WIDTH range.
// Revision    : 1.0 - initial release
// ============================================================================
package seq_alu_pkg;

    // Legal operand/result width range
    localparam int c_width_min = 8;
    localparam int c_width_max = 64;

    // Operation encodings carried on alu_op
    typedef logic [3:0] alu_op_t;

    localparam alu_op_t c_op_add   = 4'd0;
    localparam alu_op_t c_op_sub   = 4'd1;
    localparam alu_op_t c_op_and   = 4'd2;
    localparam alu_op_t c_op_orr   = 4'd3;
    localparam alu_op_t c_op_not   = 4'd4;
    localparam alu_op_t c_op_tcp   = 4'd5;
    localparam alu_op_t c_op_shl   = 4'd6;
    localparam alu_op_t c_op_shr   = 4'd7;
    localparam alu_op_t c_op_passa = 4'd8;
    localparam alu_op_t c_op_passb = 4'd9;
    localparam alu_op_t c_op_bne   = 4'd10;
    localparam alu_op_t c_op_beq   = 4'd11;
    localparam alu_op_t c_op_bgz   = 4'd12;
    localparam alu_op_t c_op_blz   = 4'd13;
    localparam alu_op_t c_op_mul   = 4'd14;
    // 4'd15 is unassigned and completes as an undefined op

    // Control FSM state encoding
    typedef logic [1:0] state_t;

    localparam state_t c_st_idle = 2'd0;
    localparam state_t c_st_mul  = 2'd1;
    localparam state_t c_st_done = 2'd2;

endpackage
`default_nettype wire

// File: rtl/seq_alu_mul.sv
`default_nettype none
// ============================================================================
// Module      : seq_alu_mul
// Description : Iterative unsigned shift-add multiplier. One partial product
//               is accumulated per clock; the WIDTH-th step is presented
//               combinationally together with o_done so the caller can
//               register the result on exactly the WIDTH-th edge after start.
// Ports       : clk        - clock
//               rst        - synchronous active-high reset (aborts operation)
//               i_start    - latch operands and begin a multiply
//               i_a, i_b   - unsigned operands
//               o_done     - final step is being presented this cycle
//               o_product  - low WIDTH bits of the product (valid with o_done)
//               o_high_nz  - high WIDTH bits of the product are non-zero
// Revision    : 1.0 - initial release
// ============================================================================
module seq_alu_mul #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_start,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic             o_done,
    output logic [WIDTH-1:0] o_product,
    output logic             o_high_nz
);

    localparam int                 c_cnt_w = $clog2(WIDTH);
    localparam logic [c_cnt_w-1:0] c_last  = c_cnt_w'(WIDTH - 1);

    logic [2*WIDTH-1:0] r_mcand;
    logic [WIDTH-1:0]   r_mplier;
    logic [2*WIDTH-1:0] r_acc;
    logic [c_cnt_w-1:0] r_cnt;
    logic               r_busy;

    logic [2*WIDTH-1:0] w_step;
    logic [2*WIDTH-1:0] w_acc_nxt;

    assign w_step    = r_mplier[0] ? r_mcand : '0;
    assign w_acc_nxt = r_acc + w_step;

    // r_cnt counts completed steps; the step with r_cnt == WIDTH-1 is the last
    assign o_done    = r_busy && (r_cnt == c_last);
    assign o_product = w_acc_nxt[WIDTH-1:0];
    assign o_high_nz = |w_acc_nxt[2*WIDTH-1:WIDTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_mcand  <= '0;
            r_mplier <= '0;
            r_acc    <= '0;
            r_cnt    <= '0;
            r_busy   <= 1'b0;
        end else if (i_start) begin
            r_mcand  <= {{WIDTH{1'b0}}, i_a};
            r_mplier <= i_b;
            r_acc    <= '0;
            r_cnt    <= '0;
            r_busy   <= 1'b1;
        end else if (r_busy) begin
            r_acc    <= w_acc_nxt;
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            r_cnt    <= r_cnt + 1'b1;
            if (o_done) begin
                r_busy <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/seq_alu.sv
`default_nettype none
// ============================================================================
// Module      : seq_alu
// Description : Sequential ALU with a valid/ready request port and a
//               valid/ready result port. Single-cycle ops complete on the
//               accepting edge; MUL runs an iterative multiplier for WIDTH
//               cycles. The result is held until the consumer takes it.
// Ports       : clk          - clock, rising edge
//               reset_n      - synchronous active-low reset
//               in_valid     - request valid
//               in_ready     - ready to accept a request (IDLE, not in reset)
//               alu_op       - operation select (seq_alu_pkg encodings)
//               alu_input_1  - operand A
//               alu_input_2  - operand B
//               out_valid    - result fields valid
//               out_ready    - consumer accepts result
//               alu_output   - result word
//               bcond        - branch condition
//               overflow     - signed ADD/SUB overflow or MUL high-half set
// Revision    : 1.0 - initial release
// ============================================================================
module seq_alu
    import seq_alu_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int MUL_EN = 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       alu_op,
    input  logic [WIDTH-1:0] alu_input_1,
    input  logic [WIDTH-1:0] alu_input_2,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] alu_output,
    output logic             bcond,
    output logic             overflow
);

    localparam bit c_mul_on = (MUL_EN != 0);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_result;
    logic             r_bcond;
    logic             r_ovf;

    logic             w_accept;
    logic             w_is_mul;
    logic [WIDTH-1:0] w_sum;
    logic [WIDTH-1:0] w_diff;
    logic [WIDTH-1:0] w_res;
    logic             w_bc;
    logic             w_ov;

    logic             w_mul_start;
    logic             w_mul_done;
    logic [WIDTH-1:0] w_mul_prod;
    logic             w_mul_high_nz;

    // in_ready is gated by reset_n so nothing is accepted while held in reset
    assign in_ready    = reset_n && (r_state == c_st_idle);
    assign w_accept    = in_valid && in_ready;
    assign w_is_mul    = c_mul_on && (alu_op == c_op_mul);
    assign w_mul_start = w_accept && w_is_mul;

    assign out_valid   = (r_state == c_st_done);
    assign alu_output  = r_result;
    assign bcond       = r_bcond;
    assign overflow    = r_ovf;

    // Single-cycle datapath evaluated on the live inputs; registered on accept
    assign w_sum  = alu_input_1 + alu_input_2;
    assign w_diff = alu_input_1 - alu_input_2;

    always_comb begin
        w_res = '0;
        w_bc  = 1'b0;
        w_ov  = 1'b0;
        case (alu_op)
            c_op_add: begin
                w_res = w_sum;
                w_ov  = (alu_input_1[WIDTH-1] == alu_input_2[WIDTH-1]) &&
                        (w_sum[WIDTH-1] != alu_input_1[WIDTH-1]);
            end
            c_op_sub: begin
                w_res = w_diff;
                w_ov  = (alu_input_1[WIDTH-1] != alu_input_2[WIDTH-1]) &&
                        (w_diff[WIDTH-1] != alu_input_1[WIDTH-1]);
            end
            c_op_and:   w_res = alu_input_1 & alu_input_2;
            c_op_orr:   w_res = alu_input_1 | alu_input_2;
            c_op_not:   w_res = ~alu_input_1;
            // Negating the most negative value wraps back to itself
            c_op_tcp:   w_res = -alu_input_1;
            c_op_shl:   w_res = {alu_input_1[WIDTH-2:0], 1'b0};
            c_op_shr:   w_res = {alu_input_1[WIDTH-1], alu_input_1[WIDTH-1:1]};
            c_op_passa: w_res = alu_input_1;
            c_op_passb: w_res = alu_input_2;
            c_op_bne:   w_bc  = (alu_input_1 != alu_input_2);
            c_op_beq:   w_bc  = (alu_input_1 == alu_input_2);
            c_op_bgz:   w_bc  = !alu_input_1[WIDTH-1] && (|alu_input_1);
            c_op_blz:   w_bc  = alu_input_1[WIDTH-1];
            // MUL (when disabled) and unassigned codes complete as all-zero
            default: ;
        endcase
    end

    generate
        if (c_mul_on) begin : g_mul
            seq_alu_mul #(
                .WIDTH(WIDTH)
            ) u_mul (
                .clk      (clk),
                .rst      (!reset_n),
                .i_start  (w_mul_start),
                .i_a      (alu_input_1),
                .i_b      (alu_input_2),
                .o_done   (w_mul_done),
                .o_product(w_mul_prod),
                .o_high_nz(w_mul_high_nz)
            );
        end else begin : g_no_mul
            assign w_mul_done    = 1'b0;
            assign w_mul_prod    = '0;
            assign w_mul_high_nz = 1'b0;
        end
    endgenerate

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_st_idle: begin
                if (w_accept) begin
                    w_state_nxt = w_is_mul ? c_st_mul : c_st_done;
                end
            end
            c_st_mul: begin
                if (w_mul_done) begin
                    w_state_nxt = c_st_done;
                end
            end
            c_st_done: begin
                if (out_ready) begin
                    w_state_nxt = c_st_idle;
                end
            end
            default: w_state_nxt = c_st_idle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state  <= c_st_idle;
            r_result <= '0;
            r_bcond  <= 1'b0;
            r_ovf    <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept && !w_is_mul) begin
                r_result <= w_res;
                r_bcond  <= w_bc;
                r_ovf    <= w_ov;
            end else if ((r_state == c_st_mul) && w_mul_done) begin
                r_result <= w_mul_prod;
                r_bcond  <= 1'b0;
                r_ovf    <= w_mul_high_nz;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_seq_alu.sv
`default_nettype none
// ============================================================================
// Module      : tb_seq_alu
// Description : Self-checking bench for seq_alu. A behavioural model predicts
//               each result and its latency; a monitor compares the DUT on
//               every cycle. A second instance covers WIDTH=32, MUL_EN=0.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seq_alu;
    import seq_alu_pkg::*;

    typedef struct {
        logic [15:0] res;
        logic        bc;
        logic        ov;
        int          lat;
        int          acc;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [3:0]  alu_op = 4'd0;
    logic [15:0] alu_input_1 = 16'd0;
    logic [15:0] alu_input_2 = 16'd0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] alu_output;
    logic        bcond;
    logic        overflow;

    logic        in_valid32 = 1'b0;
    logic        in_ready32;
    logic [3:0]  alu_op32 = 4'd0;
    logic [31:0] a32 = 32'd0;
    logic [31:0] b32 = 32'd0;
    logic        out_valid32;
    logic        out_ready32 = 1'b0;
    logic [31:0] alu_output32;
    logic        bcond32;
    logic        overflow32;

    int   vectors = 0;
    int   miscompares = 0;
    int   cyc = 0;
    exp_t exp_q[$];
    exp_t cur;
    bit   seen = 0;
    bit   prev_ov = 0;

    always #5 clk = ~clk;

    seq_alu #(.WIDTH(16), .MUL_EN(1)) dut (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
        .alu_op(alu_op), .alu_input_1(alu_input_1), .alu_input_2(alu_input_2),
        .out_valid(out_valid), .out_ready(out_ready), .alu_output(alu_output),
        .bcond(bcond), .overflow(overflow)
    );

    seq_alu #(.WIDTH(32), .MUL_EN(0)) dut32 (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid32), .in_ready(in_ready32),
        .alu_op(alu_op32), .alu_input_1(a32), .alu_input_2(b32),
        .out_valid(out_valid32), .out_ready(out_ready32), .alu_output(alu_output32),
        .bcond(bcond32), .overflow(overflow32)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Behavioural model for WIDTH=16, MUL enabled, using plain integer math
    function automatic exp_t model16(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
        exp_t   e;
        int     sa, sb, s;
        longint p;
        e.res = 16'd0; e.bc = 1'b0; e.ov = 1'b0; e.lat = 1; e.acc = 0;
        sa = a[15] ? int'(a) - 65536 : int'(a);
        sb = b[15] ? int'(b) - 65536 : int'(b);
        s  = 0;
        case (op)
            c_op_add:   begin s = sa + sb; e.res = s[15:0]; e.ov = (s > 32767) || (s < -32768); end
            c_op_sub:   begin s = sa - sb; e.res = s[15:0]; e.ov = (s > 32767) || (s < -32768); end
            c_op_and:   e.res = a & b;
            c_op_orr:   e.res = a | b;
            c_op_not:   begin s = 65535 - int'(a); e.res = s[15:0]; end
            c_op_tcp:   begin s = (65536 - int'(a)) % 65536; e.res = s[15:0]; end
            c_op_shl:   begin s = (int'(a) * 2) % 65536; e.res = s[15:0]; end
            c_op_shr:   begin s = (sa < 0) ? (sa - 1) / 2 : sa / 2; e.res = s[15:0]; end
            c_op_passa: e.res = a;
            c_op_passb: e.res = b;
            c_op_bne:   e.bc = (a != b);
            c_op_beq:   e.bc = (a == b);
            c_op_bgz:   e.bc = (sa > 0);
            c_op_blz:   e.bc = (sa < 0);
            c_op_mul:   begin
                p = longint'(a) * longint'(b);
                e.res = p[15:0];
                e.ov  = (p > 65535);
                e.lat = 17;
            end
            default: ;
        endcase
        return e;
    endfunction

    // Monitor: sampled just after every rising edge
    always @(posedge clk) begin
        cyc++;
        #1;
        if (!reset_n) begin
            chk("rst_out_valid", out_valid, 0);
            chk("rst_in_ready", in_ready, 0);
            chk("rst_out_word", {alu_output, bcond, overflow}, 0);
            exp_q.delete();
            seen = 0;
            prev_ov = 0;
        end else begin
            if (prev_ov && out_ready && exp_q.size() > 0) begin
                void'(exp_q.pop_front());
                seen = 0;
            end
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    chk("spurious_out_valid", out_valid, 0);
                end else begin
                    cur = exp_q[0];
                    chk("result", {alu_output, bcond, overflow}, {cur.res, cur.bc, cur.ov});
                    if (!seen) chk("latency", cyc - cur.acc + 1, cur.lat);
                    seen = 1;
                end
                chk("busy_in_ready", in_ready, 0);
            end else if (exp_q.size() == 0) begin
                chk("idle_in_ready", in_ready, 1);
            end else begin
                chk("mul_in_ready", in_ready, 0);
            end
            prev_ov = out_valid;
        end
    end

    // Present a request and record its expectation; returns after the accept edge
    task automatic start_op(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
        exp_t e;
        int   n;
        @(negedge clk);
        in_valid = 1'b1; alu_op = op; alu_input_1 = a; alu_input_2 = b; out_ready = 1'b0;
        #1;
        n = 0;
        while (!in_ready && n < 50) begin @(negedge clk); #1; n++; end
        if (!in_ready) begin
            chk("accept_timeout", in_ready, 1);
            in_valid = 1'b0;
            return;
        end
        e = model16(op, a, b);
        e.acc = cyc + 1;
        exp_q.push_back(e);
        @(negedge clk);
        // Scramble inputs after acceptance: the DUT must use the latched copies
        in_valid = 1'b0;
        alu_op = 4'($urandom);
        alu_input_1 = 16'($urandom);
        alu_input_2 = 16'($urandom);
    endtask

    task automatic do_op(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b, input int hold);
        int n;
        start_op(op, a, b);
        n = 0;
        while (!out_valid && n < 64) begin @(negedge clk); n++; end
        if (!out_valid) begin
            chk("done_timeout", out_valid, 1);
            exp_q.delete();
            return;
        end
        repeat (hold) @(negedge clk);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic op32(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] er, input logic eb, input logic eo);
        @(negedge clk);
        in_valid32 = 1'b1; alu_op32 = op; a32 = a; b32 = b;
        #1;
        chk("w32_in_ready", in_ready32, 1);
        @(posedge clk);
        #2;
        chk("w32_out_valid", out_valid32, 1);
        chk("w32_result", {alu_output32, bcond32, overflow32}, {er, eb, eo});
        @(negedge clk);
        in_valid32 = 1'b0; out_ready32 = 1'b1;
        @(negedge clk);
        out_ready32 = 1'b0;
        #1;
        chk("w32_back_idle", in_ready32, 1);
    endtask

    function automatic logic [15:0] pick16();
        case ($urandom_range(0, 5))
            0: return 16'h8000;
            1: return 16'h7FFF;
            2: return 16'hFFFF;
            3: return 16'h0000;
            4: return 16'($urandom_range(0, 7));
            default: return 16'($urandom);
        endcase
    endfunction

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        exp_t e;
        logic [15:0] ra, rb;
        // Pin the model against hand-computed values
        e = model16(c_op_add, 16'h7FFF, 16'h0001); chk("pin_add", {e.res, e.bc, e.ov}, {16'h8000, 1'b0, 1'b1});
        e = model16(c_op_mul, 16'h0003, 16'h0005); chk("pin_mul", {e.res, e.bc, e.ov, 8'(e.lat)}, {16'h000F, 1'b0, 1'b0, 8'd17});
        e = model16(c_op_mul, 16'h0100, 16'h0100); chk("pin_mul_ovf", {e.res, e.ov}, {16'h0000, 1'b1});
        e = model16(c_op_blz, 16'h8000, 16'h0000); chk("pin_blz", {e.res, e.bc}, {16'h0000, 1'b1});
        e = model16(c_op_bgz, 16'h8000, 16'h0000); chk("pin_bgz", {e.res, e.bc}, {16'h0000, 1'b0});
        e = model16(c_op_shr, 16'h8002, 16'h0000); chk("pin_shr", e.res, 16'hC001);
        e = model16(c_op_tcp, 16'h8000, 16'h0000); chk("pin_tcp", {e.res, e.ov}, {16'h8000, 1'b0});

        repeat (3) @(negedge clk);
        reset_n = 1'b1;

        // Directed cases
        do_op(c_op_add, 16'h7FFF, 16'h0001, 0);
        do_op(c_op_mul, 16'h0003, 16'h0005, 0);
        do_op(c_op_mul, 16'h0100, 16'h0100, 1);
        do_op(c_op_blz, 16'h8000, 16'h0000, 0);
        do_op(c_op_bgz, 16'h8000, 16'h0000, 0);
        do_op(c_op_beq, 16'h1234, 16'h1234, 0);
        do_op(c_op_shr, 16'h8002, 16'h0000, 5);
        do_op(c_op_tcp, 16'h8000, 16'h0000, 0);
        do_op(c_op_sub, 16'h8000, 16'h0001, 0);
        do_op(4'd15, 16'h1234, 16'h5678, 0);

        // Reset in the middle of a multiply: no result may appear afterwards
        start_op(c_op_mul, 16'h00FF, 16'h00FF);
        repeat (7) @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        repeat (30) @(negedge clk);
        do_op(c_op_add, 16'h0002, 16'h0003, 0);

        // Randomized traffic
        for (int i = 0; i < 80; i++) begin
            ra = pick16();
            rb = pick16();
            do_op(4'($urandom_range(0, 15)), ra, rb, $urandom_range(0, 3));
        end

        // WIDTH=32, multiplier disabled
        op32(c_op_mul, 32'd5, 32'd7, 32'd0, 1'b0, 1'b0);
        op32(4'd15, 32'hFFFF_FFFF, 32'h1, 32'd0, 1'b0, 1'b0);
        op32(c_op_add, 32'h7FFF_FFFF, 32'h1, 32'h8000_0000, 1'b0, 1'b1);
        op32(c_op_blz, 32'h8000_0000, 32'h0, 32'd0, 1'b1, 1'b0);

        repeat (3) @(negedge clk);
        chk("queue_drained", 64'(exp_q.size()), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
